conv_mac_unit: RTL and testbench
================================

# conv_mac_unit

Multi-cycle convolution coprocessor in the execute stage, consuming the custom ALU control codes produced by the ALU control decoder. Code 3'b100 (load) writes one entry of a 9-tap kernel buffer or a 9-entry pixel-window buffer in a single cycle. Code 3'b111 (conv) starts a 9-cycle signed multiply-accumulate over the two buffers. While the MAC runs, the block stalls the pipeline, then presents a 32-bit result for one cycle.

## Interface
- TAPS, 9, number of kernel/window entries; index width is $clog2(TAPS)
- PIX_W, 8, pixel width, unsigned
- WGT_W, 8, weight width, signed two's complement
- ACC_W, 32, accumulator and result width

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  execute-stage instruction valid
- ALUControl  in  3  3'b100 = load entry, 3'b111 = conv start, all other codes ignored
- SrcA  in  32  load: [4] buffer select (0 = kernel, 1 = pixel), [3:0] entry index; conv: ignored
- SrcB  in  32  load: [7:0] value to write; conv: ignored
- Stall  out  1  hold the fetch/decode/execute stages
- ResultValid  out  1  one-cycle pulse when Result carries a fresh conv result
- Result  out  ACC_W  last conv result, held until the next one completes

## Operation
- State machine: IDLE, RUN, DONE.
- start = en & (ALUControl == 3'b111) & (state == IDLE).
- load = en & (ALUControl == 3'b100) & (state == IDLE).
- Load
  - On load, the entry SrcA[3:0] of the buffer selected by SrcA[4] takes SrcB[7:0] at the clock edge.
  - Index >= TAPS: the write is dropped and no buffer changes.
  - Loads never stall.
- IDLE
  - On start: acc <= 0, idx <= 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN
  - Each cycle: acc <= acc + sext(w[idx]) * zext(p[idx]), idx <= idx + 1.
  - Product is signed, WGT_W+PIX_W+1 bits, sign-extended to ACC_W.
  - On the MAC with idx == TAPS-1: Result <= final sum, go to DONE.
- DONE
  - ResultValid = 1.
  - Go to IDLE unconditionally. A conv code still present on en/ALUControl in this cycle is the retiring instruction and does not restart.
- Arithmetic: the accumulator wraps modulo 2^ACC_W. At default parameters the worst case is ±293760, so no wrap occurs.
- en/ALUControl seen in RUN or DONE are ignored, including loads. The pipeline guarantees they are the held conv instruction.

## Timing
- Stall = rst & (start | state == RUN). Combinational from inputs in IDLE, so the conv instruction holds in execute during its start cycle.
- Conv accepted at edge ending cycle T (start = 1, Stall = 1).
- Cycles T+1 … T+9: RUN, one MAC per cycle, Stall = 1.
- Cycle T+10: DONE, Stall = 0, ResultValid = 1, Result valid. The instruction advances at the end of T+10.
- Start-to-result latency is 10 cycles.
- Earliest next conv start is T+11, giving a back-to-back throughput of 11 cycles per conv.
- Load written at the edge ending its cycle. A conv issued in the next cycle sees the new value.
- Reset (rst low, any time)
  - state = IDLE, acc = 0, idx = 0, both buffers cleared to 0, Result = 0, ResultValid = 0, Stall = 0.
  - A conv in flight is aborted with no ResultValid pulse.
- After rst deasserts, the first edge may accept a start or load.

## Test plan
- Kernel all +1, pixels 1..9, conv at T → Stall high T..T+9, ResultValid pulse at T+10 only, Result = 45 (0x2D), held afterwards.
- Kernel all -128, pixels all 255 → Result = 0xFFFB8480 (-293760); check sign extension of every product.
- Load with SrcA = 0x0F and 0x1A, SrcB = 0x7F → no buffer change. The following conv with previously loaded kernel 1..9 and pixels all 1 still returns 45. Stall stays 0 during the loads.
- Conv started, rst pulsed low at T+4 → Stall = 0 immediately, no ResultValid. A new conv on zeroed buffers returns 0.
- Two convs back-to-back: conv code held through T+10, then a new conv at T+11 → exactly one pulse at T+10, the second pulse at T+21, no spurious restart at T+10.
- Load issued while state = RUN (forced stimulus) → ignored. The result equals that computed from the pre-start buffer contents.

Source files
------------

// File: rtl/conv_mac_unit.sv
// Execute-stage convolution coprocessor: kernel/pixel buffer loads plus a
// stalling 9-cycle signed MAC that reports its sum with a one-cycle valid pulse.
module conv_mac_unit #(
    parameter int unsigned TAPS  = 9,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       ALUControl,
    input  logic [31:0]      SrcA,
    input  logic [31:0]      SrcB,
    output logic             Stall,
    output logic             ResultValid,
    output logic [ACC_W-1:0] Result
);

    localparam int unsigned IDX_W  = $clog2(TAPS);
    localparam int unsigned PROD_W = WGT_W + PIX_W + 1;
    localparam logic [2:0]  OP_LOAD = 3'b100;
    localparam logic [2:0]  OP_CONV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic [WGT_W-1:0]   kern_q [TAPS];
    logic [PIX_W-1:0]   pix_q  [TAPS];

    logic               start_c;
    logic               load_c;
    logic [3:0]         ld_idx_c;
    logic               ld_ok_c;
    logic signed [PROD_W-1:0] w_ext_c;
    logic signed [PROD_W-1:0] p_ext_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [ACC_W-1:0]   prod_ext_c;
    logic [ACC_W-1:0]   mac_sum_c;
    logic               unused_bits;

    assign start_c  = en && (ALUControl == OP_CONV) && (state_q == S_IDLE);
    assign load_c   = en && (ALUControl == OP_LOAD) && (state_q == S_IDLE);
    assign ld_idx_c = SrcA[3:0];
    assign ld_ok_c  = (32'(ld_idx_c) < TAPS);
    assign unused_bits = ^{SrcA, SrcB};

    // Weight is sign-extended, pixel zero-extended, so the product is exact in PROD_W bits.
    assign w_ext_c    = {{(PROD_W-WGT_W){kern_q[idx_q][WGT_W-1]}}, kern_q[idx_q]};
    assign p_ext_c    = {{(PROD_W-PIX_W){1'b0}}, pix_q[idx_q]};
    assign prod_c     = w_ext_c * p_ext_c;
    assign prod_ext_c = {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
    assign mac_sum_c  = acc_q + prod_ext_c;

    // Buffer writes only happen from IDLE; out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                kern_q[i] <= '0;
                pix_q[i]  <= '0;
            end
        end else if (load_c && ld_ok_c) begin
            if (SrcA[4]) begin
                pix_q[IDX_W'(ld_idx_c)]  <= SrcB[PIX_W-1:0];
            end else begin
                kern_q[IDX_W'(ld_idx_c)] <= SrcB[WGT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = mac_sum_c;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    result_d = mac_sum_c;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            // The conv code still present here is the retiring instruction.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Combinational so the conv instruction holds in execute during its start cycle.
    assign Stall       = rst && (start_c || (state_q == S_RUN));
    assign ResultValid = valid_q;
    assign Result      = result_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Randomised self-checking bench for conv_mac_unit against a plain dot-product model.
module tb_conv_mac_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Stall;
    logic        ResultValid;
    logic [31:0] Result;

    int tests = 0;
    int fails = 0;

    byte        km [9];
    logic [7:0] pm [9];

    always #5 clk = ~clk;

    conv_mac_unit #(.TAPS(9), .PIX_W(8), .WGT_W(8), .ACC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ALUControl  (ALUControl),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Stall       (Stall),
        .ResultValid (ResultValid),
        .Result      (Result)
    );

    function automatic logic [31:0] conv_ref();
        int acc = 0;
        for (int i = 0; i < 9; i++) acc += int'(km[i]) * int'(pm[i]);
        return 32'(acc);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 9; i++) begin
            km[i] = 0;
            pm[i] = 8'h00;
        end
    endfunction

    task automatic drive(input logic e, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        en = e; ALUControl = c; SrcA = a; SrcB = b;
    endtask

    task automatic do_load(input bit sel, input logic [3:0] idx, input logic [7:0] val);
        @(posedge clk); #1;
        drive(1'b1, 3'b100, {27'b0, sel, idx}, {24'h0, val});
        #3;
        tests++;
        if (Stall !== 1'b0) begin
            fails++;
            $display("FAIL load_stall idx=%0d: Stall=%b expected 0", idx, Stall);
        end
        if (idx < 9) begin
            if (sel) pm[idx] = val;
            else     km[idx] = byte'(val);
        end
    endtask

    task automatic run_conv(input string name, input logic [31:0] exp, input bit inject);
        @(posedge clk); #1;
        drive(1'b1, 3'b111, $urandom, $urandom);
        #3;
        tests++;
        if (Stall !== 1'b1 || ResultValid !== 1'b0) begin
            fails++;
            $display("FAIL %s start: Stall=%b ResultValid=%b expected 1/0", name, Stall, ResultValid);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (inject && k >= 2 && k <= 6)
                drive(1'b1, 3'b100, $urandom_range(0, 31), $urandom);
            else
                drive(1'b1, 3'b111, $urandom, $urandom);
            #3;
            tests++;
            if (k < 10) begin
                if (Stall !== 1'b1 || ResultValid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s run T+%0d: Stall=%b ResultValid=%b expected 1/0", name, k, Stall, ResultValid);
                end
            end else begin
                if (Stall !== 1'b0 || ResultValid !== 1'b1 || Result !== exp) begin
                    fails++;
                    $display("FAIL %s done: Stall=%b ResultValid=%b Result=%h expected 0/1/%h",
                             name, Stall, ResultValid, Result, exp);
                end
            end
        end
    endtask

    task automatic idle_check(input string name, input logic [31:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            drive(1'b0, 3'b000, 32'h0, 32'h0);
            #3;
            tests++;
            if (Stall !== 1'b0 || ResultValid !== 1'b0 || Result !== exp) begin
                fails++;
                $display("FAIL %s idle%0d: Stall=%b ResultValid=%b Result=%h expected 0/0/%h",
                         name, k, Stall, ResultValid, Result, exp);
            end
        end
    endtask

    task automatic load_random_all();
        for (int i = 0; i < 9; i++) begin
            do_load(1'b0, 4'(i), 8'($urandom));
            do_load(1'b1, 4'(i), 8'($urandom));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        clear_model();
        #12;
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0 || Result !== 32'h0) begin
            fails++;
            $display("FAIL reset: Stall=%b ResultValid=%b Result=%h expected 0/0/0", Stall, ResultValid, Result);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 9; i++) begin
            do_load(1'b0, 4'(i), 8'd1);
            do_load(1'b1, 4'(i), 8'(i + 1));
        end
        run_conv("ramp", conv_ref(), 1'b0);
        idle_check("ramp_hold", conv_ref(), 3);
    endtask

    task automatic test_neg_extreme();
        for (int i = 0; i < 9; i++) begin
            do_load(1'b0, 4'(i), 8'h80);
            do_load(1'b1, 4'(i), 8'hFF);
        end
        run_conv("neg_extreme", conv_ref(), 1'b0);
        idle_check("neg_extreme_hold", conv_ref(), 1);
    endtask

    task automatic test_bad_index();
        for (int i = 0; i < 9; i++) begin
            do_load(1'b0, 4'(i), 8'(i + 1));
            do_load(1'b1, 4'(i), 8'd1);
        end
        do_load(1'b0, 4'hF, 8'h7F);
        do_load(1'b1, 4'hA, 8'h7F);
        run_conv("bad_index", conv_ref(), 1'b0);
        idle_check("bad_index_hold", conv_ref(), 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            load_random_all();
            for (int j = 0; j < 4; j++)
                do_load(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
            run_conv("random", conv_ref(), 1'b0);
            idle_check("random_hold", conv_ref(), 1);
        end
    endtask

    task automatic test_abort();
        load_random_all();
        @(posedge clk); #1;
        drive(1'b1, 3'b111, 32'h0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (Stall !== 1'b0 || ResultValid !== 1'b0) begin
            fails++;
            $display("FAIL abort: Stall=%b ResultValid=%b expected 0/0", Stall, ResultValid);
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        clear_model();
        idle_check("abort_quiet", 32'h0, 12);
        run_conv("abort_zero", conv_ref(), 1'b0);
        idle_check("abort_zero_hold", conv_ref(), 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        load_random_all();
        exp = conv_ref();
        run_conv("b2b_first", exp, 1'b0);
        run_conv("b2b_second", exp, 1'b0);
        idle_check("b2b_hold", exp, 2);
    endtask

    task automatic test_load_in_run();
        load_random_all();
        run_conv("load_in_run", conv_ref(), 1'b1);
        idle_check("load_in_run_hold", conv_ref(), 1);
        run_conv("load_in_run_again", conv_ref(), 1'b0);
        idle_check("load_in_run_again_hold", conv_ref(), 1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_neg_extreme();
        test_bad_index();
        test_random();
        test_abort();
        test_back_to_back();
        test_load_in_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
